// File: rtl/jogo_pkg.sv
// Shared breakout definitions: screen size, ball FSM states and direction encoding.
package jogo_pkg;
   localparam int LARGURA_TELA = 640;
   localparam int ALTURA_TELA  = 480;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      MOVENDO = 2'd1,
      PERDIDA = 2'd2
   } estado_t;

   localparam logic DIR_DIREITA  = 1'b1;
   localparam logic DIR_ESQUERDA = 1'b0;
   localparam logic DIR_CIMA     = 1'b0;
   localparam logic DIR_BAIXO    = 1'b1;
endpackage

// File: rtl/bola_if.sv
// Ship <-> ball link: ship geometry and launch request in, hit pulse back.
interface bola_if;
   logic       iniciarBola;
   logic [9:0] x_nave;
   logic [9:0] y_nave;
   logic [9:0] largura_nave;
   logic [9:0] altura_nave;
   logic       bateu;

   modport master (output iniciarBola, x_nave, y_nave, largura_nave, altura_nave,
                   input  bateu);
   modport slave  (input  iniciarBola, x_nave, y_nave, largura_nave, altura_nave,
                   output bateu);
endinterface

// File: rtl/divisor_tick.sv
// Free-running 0..DIV-1 divider; tick is combinational on the last count while enabled.
module divisor_tick #(
   parameter int DIV = 100000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign tick = enable && !clear && (cnt == ULTIMO);

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= (cnt == ULTIMO) ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/bola.sv
// Breakout ball: rides on the ship until launched, then bounces off walls and ship.
// Outputs are registered; one position step per divider tick.
module bola
   import jogo_pkg::*;
#(
   parameter int LARGURA_TELA = jogo_pkg::LARGURA_TELA,
   parameter int ALTURA_TELA  = jogo_pkg::ALTURA_TELA,
   parameter int TAM_BOLA     = 8,
   parameter int DIV_TICK     = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       pausa,
   input  logic       reiniciarJogo,
   bola_if.slave      nave,
   output logic [9:0] x_bola,
   output logic [9:0] y_bola,
   output logic       perdeu,
   output logic       em_jogo
);
   localparam logic [10:0] TAM11  = 11'(TAM_BOLA);
   localparam logic [10:0] LARG11 = 11'(LARGURA_TELA);
   localparam logic [10:0] ALT11  = 11'(ALTURA_TELA);

   estado_t     estado, prox;
   logic        dir_x, dir_y, bateu;
   logic        tick, perda, acerto, ndir_x, ndir_y, lancar;
   logic [10:0] x_ext, y_ext, x_fim, y_fim, nave_ini, nave_fim;
   logic [9:0]  x_espera, y_espera, x_prox, y_prox;
   logic        unused_altura;

   assign unused_altura = ^nave.altura_nave;
   assign nave.bateu    = bateu;
   assign lancar        = nave.iniciarBola && !pausa;

   divisor_tick #(.DIV(DIV_TICK)) u_tick (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .enable   (estado == MOVENDO && !pausa),
      .clear    (reiniciarJogo || estado != MOVENDO),
      .tick     (tick)
   );

   // 11-bit sums so edge comparisons never wrap
   assign x_ext    = {1'b0, x_bola};
   assign y_ext    = {1'b0, y_bola};
   assign x_fim    = x_ext + TAM11;
   assign y_fim    = y_ext + TAM11;
   assign nave_ini = {1'b0, nave.x_nave};
   assign nave_fim = nave_ini + {1'b0, nave.largura_nave};
   assign x_espera = nave.x_nave + (nave.largura_nave >> 1) - 10'(TAM_BOLA / 2);
   assign y_espera = nave.y_nave - 10'(TAM_BOLA);
   assign perda    = (y_fim >= ALT11);

   always_comb begin
      ndir_x = dir_x;
      ndir_y = dir_y;
      acerto = 1'b0;
      if (dir_x == DIR_DIREITA && x_fim >= LARG11)
         ndir_x = DIR_ESQUERDA;
      else if (dir_x == DIR_ESQUERDA && x_bola == '0)
         ndir_x = DIR_DIREITA;
      if (dir_y == DIR_CIMA && y_bola == '0)
         ndir_y = DIR_BAIXO;
      // ship test sees the direction after the top-wall bounce
      if (ndir_y == DIR_BAIXO && y_fim == {1'b0, nave.y_nave} &&
          x_fim > nave_ini && x_ext < nave_fim) begin
         ndir_y = DIR_CIMA;
         acerto = 1'b1;
      end
   end

   assign x_prox = (ndir_x == DIR_DIREITA) ? x_bola + 10'd1 : x_bola - 10'd1;
   assign y_prox = (ndir_y == DIR_BAIXO)   ? y_bola + 10'd1 : y_bola - 10'd1;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset)
         estado <= ESPERA;
      else
         estado <= prox;
   end

   always_comb begin
      prox = estado;
      if (reiniciarJogo)
         prox = ESPERA;
      else begin
         case (estado)
            ESPERA:  if (lancar) prox = MOVENDO;
            MOVENDO: if (tick && perda) prox = PERDIDA;
            PERDIDA: prox = ESPERA;
            default: prox = ESPERA;
         endcase
      end
   end

   always_comb begin
      em_jogo = (estado == MOVENDO);
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         x_bola <= '0;
         y_bola <= '0;
         dir_x  <= DIR_DIREITA;
         dir_y  <= DIR_CIMA;
         bateu  <= 1'b0;
         perdeu <= 1'b0;
      end else begin
         bateu  <= 1'b0;
         perdeu <= 1'b0;
         if (reiniciarJogo) begin
            dir_x <= DIR_DIREITA;
            dir_y <= DIR_CIMA;
         end else begin
            case (estado)
               ESPERA: begin
                  x_bola <= x_espera;
                  y_bola <= y_espera;
                  if (lancar) begin
                     dir_x <= DIR_DIREITA;
                     dir_y <= DIR_CIMA;
                  end
               end
               MOVENDO: begin
                  if (tick) begin
                     if (perda)
                        perdeu <= 1'b1;
                     else begin
                        dir_x  <= ndir_x;
                        dir_y  <= ndir_y;
                        x_bola <= x_prox;
                        y_bola <= y_prox;
                        bateu  <= acerto;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bola.sv
// Bench for bola: directed scenarios plus randomized traffic against a velocity-based model.
module tb_bola;
   localparam int DIV = 4;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       pausa;
   logic       reiniciarJogo;
   logic [9:0] x_bola, y_bola;
   logic       perdeu, em_jogo;

   int n_chk  = 0;
   int n_fail = 0;

   bola_if nave();

   bola #(.DIV_TICK(DIV)) dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .pausa         (pausa),
      .reiniciarJogo (reiniciarJogo),
      .nave          (nave),
      .x_bola        (x_bola),
      .y_bola        (y_bola),
      .perdeu        (perdeu),
      .em_jogo       (em_jogo)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Reference: mode 0 waiting, 1 flying, 2 lost; velocities are +1/-1 (vy>0 = down)
   int m_modo, m_x, m_y, m_vx, m_vy, m_fase;
   bit m_bateu, m_perdeu;

   always @(posedge CLOCK_50 or negedge reset) begin
      int xn, yn, wn;
      xn = int'(nave.x_nave);
      yn = int'(nave.y_nave);
      wn = int'(nave.largura_nave);
      if (!reset) begin
         m_modo = 0; m_x = 0; m_y = 0; m_vx = 1; m_vy = -1; m_fase = 0;
         m_bateu = 0; m_perdeu = 0;
      end else begin
         m_bateu = 0;
         m_perdeu = 0;
         if (reiniciarJogo) begin
            m_modo = 0; m_fase = 0; m_vx = 1; m_vy = -1;
         end else if (m_modo == 0) begin
            m_x = (xn + wn / 2 - 4) & 1023;
            m_y = (yn - 8) & 1023;
            if (nave.iniciarBola && !pausa) begin
               m_modo = 1; m_fase = 0; m_vx = 1; m_vy = -1;
            end
         end else if (m_modo == 2) begin
            m_modo = 0;
         end else if (!pausa) begin
            if (m_fase != DIV - 1)
               m_fase++;
            else begin
               m_fase = 0;
               if (m_y + 8 >= 480) begin
                  m_modo = 2;
                  m_perdeu = 1;
               end else begin
                  if (m_vx > 0 && m_x + 8 >= 640) m_vx = -1;
                  else if (m_vx < 0 && m_x == 0) m_vx = 1;
                  if (m_vy < 0 && m_y == 0) m_vy = 1;
                  if (m_vy > 0 && m_y + 8 == yn && m_x + 8 > xn && m_x < xn + wn) begin
                     m_vy = -1;
                     m_bateu = 1;
                  end
                  m_x += m_vx;
                  m_y += m_vy;
               end
            end
         end
      end
   end

   task automatic set_nave(input int xn, input int yn, input int wn);
      nave.x_nave       = 10'(xn);
      nave.y_nave       = 10'(yn);
      nave.largura_nave = 10'(wn);
   endtask

   task automatic test_reset();
      reset = 1'b0; pausa = 1'b0; reiniciarJogo = 1'b0; nave.iniciarBola = 1'b0;
      nave.altura_nave = 10'd16;
      set_nave(350, 420, 30);
      repeat (2) @(negedge CLOCK_50);
      n_chk++;
      if ({x_bola, y_bola} !== {10'd0, 10'd0}) begin
         n_fail++; $display("FAIL reset_pos: got (%0d,%0d) expected (0,0)", x_bola, y_bola);
      end
      n_chk++;
      if ({em_jogo, nave.bateu, perdeu} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got em/bateu/perdeu=%b%b%b expected 000", em_jogo, nave.bateu, perdeu);
      end
      reset = 1'b1;
      @(negedge CLOCK_50);
      n_chk++;
      if ({x_bola, y_bola} !== {10'd361, 10'd412}) begin
         n_fail++; $display("FAIL track_after_reset: got (%0d,%0d) expected (361,412)", x_bola, y_bola);
      end
      n_chk++;
      if ({em_jogo, nave.bateu} !== 2'b00) begin
         n_fail++; $display("FAIL idle_flags: got em/bateu=%b%b expected 00", em_jogo, nave.bateu);
      end
   endtask

   task automatic test_launch();
      nave.iniciarBola = 1'b1;   // held high afterwards: must be ignored while flying
      @(negedge CLOCK_50);
      n_chk++;
      if (em_jogo !== 1'b1) begin
         n_fail++; $display("FAIL launch_em_jogo: got %b expected 1", em_jogo);
      end
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLOCK_50);
         n_chk++;
         if ({x_bola, y_bola, em_jogo} !== {10'(361 + c / 4), 10'(412 - c / 4), 1'b1}) begin
            n_fail++;
            $display("FAIL launch_step c=%0d: got (%0d,%0d) em=%b expected (%0d,%0d) em=1",
                     c, x_bola, y_bola, em_jogo, 361 + c / 4, 412 - c / 4);
         end
      end
      nave.iniciarBola = 1'b0;
   endtask

   task automatic test_restart();
      reiniciarJogo = 1'b1;
      @(negedge CLOCK_50);
      reiniciarJogo = 1'b0;
      n_chk++;
      if ({em_jogo, nave.bateu, perdeu} !== 3'b000) begin
         n_fail++; $display("FAIL restart_flags: got em/bateu/perdeu=%b%b%b expected 000", em_jogo, nave.bateu, perdeu);
      end
      @(negedge CLOCK_50);
      n_chk++;
      if ({x_bola, y_bola} !== {10'd361, 10'd412}) begin
         n_fail++; $display("FAIL restart_track: got (%0d,%0d) expected (361,412)", x_bola, y_bola);
      end
   endtask

   task automatic test_pause();
      nave.iniciarBola = 1'b1;
      @(negedge CLOCK_50);
      nave.iniciarBola = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      pausa = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLOCK_50);
         n_chk++;
         if ({x_bola, y_bola, em_jogo, nave.bateu, perdeu} !== {10'd361, 10'd412, 3'b100}) begin
            n_fail++;
            $display("FAIL pause_frozen c=%0d: got (%0d,%0d) em/b/p=%b%b%b expected (361,412) 100",
                     c, x_bola, y_bola, em_jogo, nave.bateu, perdeu);
         end
      end
      pausa = 1'b0;
      @(negedge CLOCK_50);
      n_chk++;
      if ({x_bola, y_bola} !== {10'd361, 10'd412}) begin
         n_fail++; $display("FAIL pause_resume_early: got (%0d,%0d) expected (361,412)", x_bola, y_bola);
      end
      @(negedge CLOCK_50);
      n_chk++;
      if ({x_bola, y_bola} !== {10'd362, 10'd411}) begin
         n_fail++; $display("FAIL pause_resume_step: got (%0d,%0d) expected (362,411)", x_bola, y_bola);
      end
      reiniciarJogo = 1'b1;
      @(negedge CLOCK_50);
      reiniciarJogo = 1'b0;
   endtask

   // Right wall, top wall, ship bounce, (0,0) corner, miss beside the ship, then loss.
   task automatic test_long_flight();
      int n_bateu = 0;
      int n_perdeu = 0;
      set_nave(628, 108, 16);
      @(negedge CLOCK_50);
      n_chk++;
      if ({x_bola, y_bola} !== {10'd632, 10'd100}) begin
         n_fail++; $display("FAIL wall_start: got (%0d,%0d) expected (632,100)", x_bola, y_bola);
      end
      nave.iniciarBola = 1'b1;
      @(negedge CLOCK_50);
      nave.iniciarBola = 1'b0;
      set_nave(250, 274, 40);
      for (int k = 1; k <= 633 + 472; k++) begin
         if (k == 634) set_nave(350, 420, 30);
         for (int c = 0; c < DIV; c++) begin
            @(negedge CLOCK_50);
            n_bateu  += int'(nave.bateu);
            n_perdeu += int'(perdeu);
            n_chk++;
            if ({x_bola, y_bola, em_jogo, nave.bateu, perdeu} !==
                {10'(m_x), 10'(m_y), m_modo == 1, m_bateu, m_perdeu}) begin
               n_fail++;
               $display("FAIL long_model step=%0d: got (%0d,%0d) em/b/p=%b%b%b expected (%0d,%0d) em/b/p=%b%b%b",
                        k, x_bola, y_bola, em_jogo, nave.bateu, perdeu, m_x, m_y, m_modo == 1, m_bateu, m_perdeu);
            end
         end
         if (k == 1) begin
            n_chk++;
            if ({x_bola, y_bola} !== {10'd631, 10'd99}) begin
               n_fail++; $display("FAIL right_wall: got (%0d,%0d) expected (631,99)", x_bola, y_bola);
            end
         end
         if (k == 367) begin
            n_chk++;
            if ({nave.bateu, x_bola, y_bola} !== {1'b1, 10'd265, 10'd265}) begin
               n_fail++; $display("FAIL ship_hit: got bateu=%b (%0d,%0d) expected bateu=1 (265,265)", nave.bateu, x_bola, y_bola);
            end
         end
         if (k == 633) begin
            n_chk++;
            if ({x_bola, y_bola, n_bateu} !== {10'd1, 10'd1, 32'd1}) begin
               n_fail++; $display("FAIL corner: got (%0d,%0d) bateu_cycles=%0d expected (1,1) 1", x_bola, y_bola, n_bateu);
            end
         end
      end
      n_chk++;
      if ({perdeu, em_jogo, x_bola, y_bola, n_bateu, n_perdeu} !== {2'b10, 10'd472, 10'd472, 32'd1, 32'd1}) begin
         n_fail++;
         $display("FAIL loss: got perdeu=%b em=%b (%0d,%0d) bateu_cycles=%0d perdeu_cycles=%0d expected 1 0 (472,472) 1 1",
                  perdeu, em_jogo, x_bola, y_bola, n_bateu, n_perdeu);
      end
      @(negedge CLOCK_50);
      n_chk++;
      if ({perdeu, em_jogo} !== 2'b00) begin
         n_fail++; $display("FAIL loss_pulse_end: got perdeu=%b em=%b expected 0 0", perdeu, em_jogo);
      end
      @(negedge CLOCK_50);
      n_chk++;
      if ({x_bola, y_bola} !== {10'd361, 10'd412}) begin
         n_fail++; $display("FAIL loss_snap: got (%0d,%0d) expected (361,412)", x_bola, y_bola);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLOCK_50);
         n_chk++;
         if ({x_bola, y_bola, em_jogo, nave.bateu, perdeu} !==
             {10'(m_x), 10'(m_y), m_modo == 1, m_bateu, m_perdeu}) begin
            n_fail++;
            $display("FAIL rand_model c=%0d: got (%0d,%0d) em/b/p=%b%b%b expected (%0d,%0d) em/b/p=%b%b%b",
                     c, x_bola, y_bola, em_jogo, nave.bateu, perdeu, m_x, m_y, m_modo == 1, m_bateu, m_perdeu);
         end
         n_chk++;
         if ((nave.bateu & perdeu) !== 1'b0) begin
            n_fail++; $display("FAIL rand_pulse_overlap c=%0d: got bateu&perdeu=%b expected 0", c, nave.bateu & perdeu);
         end
         pausa            = ($urandom_range(7) == 0);
         nave.iniciarBola = ($urandom_range(15) == 0);
         reiniciarJogo    = ($urandom_range(199) == 0);
         if ($urandom_range(49) == 0)
            set_nave(int'($urandom_range(600)), int'($urandom_range(470, 16)), int'($urandom_range(40, 8)));
         if (c == 1502) reset = 1'b1;
         if (c == 1500) begin
            #3 reset = 1'b0;
            #1;
            n_chk++;
            if ({x_bola, y_bola, em_jogo, nave.bateu, perdeu} !== {10'd0, 10'd0, 3'b000}) begin
               n_fail++;
               $display("FAIL async_reset: got (%0d,%0d) em/b/p=%b%b%b expected (0,0) 000",
                        x_bola, y_bola, em_jogo, nave.bateu, perdeu);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_launch();
      test_restart();
      test_pause();
      test_long_flight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bola.md
Name: bola

Overview:
- Ball controller for the breakout game; it is the consumer side of the ship interface.
- Takes the ship position/size and the launch request `iniciarBola` from the ship block.
- Moves the ball and reflects it off the walls and the ship.
- Returns `bateu` to the ship block; reports a lost ball to game control.
- Output position feeds the VGA renderer.

Parameters:
- LARGURA_TELA, 640, visible width in pixels
- ALTURA_TELA, 480, visible height in pixels
- TAM_BOLA, 8, ball side in pixels (square)
- DIV_TICK, 100000, CLOCK_50 cycles per movement step (500 Hz); benches use 4

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- pausa  in  1  1 = freeze movement and tick counter
- reiniciarJogo  in  1  synchronous restart to ESPERA
- iniciarBola  in  1  launch request from ship block
- x_nave  in  10  ship left x
- y_nave  in  10  ship top y
- largura_nave  in  10  ship width
- altura_nave  in  10  ship height (reserved, unused for collision)
- x_bola  out  10  ball left x (registered)
- y_bola  out  10  ball top y (registered)
- bateu  out  1  one-cycle pulse: ball reflected off ship
- perdeu  out  1  one-cycle pulse: ball passed bottom edge
- em_jogo  out  1  1 while state == MOVENDO

Behaviour:
- Reset (reset=0, asynchronous):
  - state = ESPERA; x_bola = 0, y_bola = 0; dir_x = 1 (right), dir_y = 0 (up).
  - bateu = 0, perdeu = 0, tick counter = 0.
- States: ESPERA, MOVENDO, PERDIDA.
- ESPERA:
  - Every clock, regardless of pausa: x_bola = x_nave + largura_nave/2 - TAM_BOLA/2, y_bola = y_nave - TAM_BOLA.
  - All arithmetic is 10-bit truncating.
  - Tracking starts on the first clock after reset release.
  - iniciarBola=1 and pausa=0 -> MOVENDO next clock, with dir_x=1, dir_y=0 and the tick counter cleared.
- MOVENDO:
  - Tick counter counts 0..DIV_TICK-1 and wraps. It holds its value while pausa=1.
  - Step fires on the cycle where counter == DIV_TICK-1 and pausa=0.
  - On a step, evaluate the following on the current registered values, in order:
    1. Loss: y_bola + TAM_BOLA >= ALTURA_TELA -> PERDIDA; no position change.
    2. X reflection: dir_x=1 and x_bola + TAM_BOLA >= LARGURA_TELA -> dir_x=0. dir_x=0 and x_bola == 0 -> dir_x=1.
    3. Y top reflection: dir_y=0 and y_bola == 0 -> dir_y=1.
    4. Ship hit: dir_y=1 and y_bola + TAM_BOLA == y_nave and x_bola + TAM_BOLA > x_nave and x_bola < x_nave + largura_nave -> dir_y=0, bateu=1 next cycle.
    5. Move: x_bola ±1 per the updated dir_x; y_bola ±1 per the updated dir_y (1 = down).
  - Simultaneous events:
    - Corner: X and Y reflections both apply in the same step.
    - Ship hit plus side wall: both apply; bateu still pulses.
  - Position never leaves 0..LARGURA_TELA-TAM_BOLA horizontally while moving.
- PERDIDA:
  - perdeu = 1 for exactly one clock.
  - Next clock -> ESPERA, which resumes tracking.
- bateu and perdeu:
  - Registered; high for exactly one cycle per event; never high at the same time.
- pausa=1 in MOVENDO:
  - Position, directions and counter frozen; no pulses issued.
  - Resuming continues from the frozen counter value.
- reiniciarJogo=1 (any state, synchronous, priority over everything except reset):
  - state = ESPERA, counter = 0, bateu = 0, perdeu = 0, dir_x=1, dir_y=0.
  - Position follows the ESPERA rule from the next clock.
- iniciarBola while already in MOVENDO: ignored.
- Reset asserted mid-step: all state returns to reset values immediately.

Decomposition:
- Shared package `jogo_pkg`:
  - Screen constants LARGURA_TELA and ALTURA_TELA (reused by nave/VGA).
  - State encoding ESPERA/MOVENDO/PERDIDA.
  - Direction constants DIR_DIREITA/DIR_ESQUERDA/DIR_CIMA/DIR_BAIXO.
- One sub-module `divisor_tick` (parameter DIV, inputs CLOCK_50/reset/enable/clear, output 1-cycle `tick`). It is reusable for nave speed later.
- Collision and FSM logic stay in `bola`.

Test Plan:
- Reset then release, with x_nave=350, y_nave=420, largura=30 -> next clock x_bola=361, y_bola=412, em_jogo=0, bateu=0.
- iniciarBola=1 pulse, DIV_TICK=4 -> em_jogo=1 next clock. After 4 clocks x_bola=362, y_bola=411; it then moves +1/-1 every 4 clocks.
- Force x_bola=632 (640-8) with dir_x=1 on a step -> dir_x becomes 0 and x_bola=631. Corner at (0,0) with dir up-left -> both flip, and the ball goes to (1,1).
- Ball descending, x_bola=355, y_bola=412, ship at (350,420) width 30, step -> bateu high exactly 1 cycle, y_bola=411. At x_bola=380 (no overlap) -> no bateu, descent continues.
- Ball descends past y_bola=472 with no ship below -> perdeu high exactly 1 cycle, then em_jogo=0 and the ball snaps above the ship.
- pausa=1 for 20 clocks mid-flight -> x_bola/y_bola constant, no pulses; after release the first step arrives after the remaining counter cycles. reiniciarJogo mid-flight -> ESPERA next clock.
